// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter that time-shares one SPI master among N_REQ byte-level clients.
// Sequences SS, SPCR/SPIBR setup, the SPDR load strobe and SPIF completion (with timeout).
module spi_xfer_arbiter #(
   parameter int N_REQ       = 4,
   parameter int SS_GAP      = 4,
   parameter int SETUP_CYC   = 2,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req,
   input  logic [8*N_REQ-1:0] tx_data,
   input  logic [N_REQ-1:0]   lock,
   input  logic               cfg_cpol,
   input  logic               cfg_cpha,
   input  logic [7:0]         cfg_prescale,
   output logic [N_REQ-1:0]   gnt,
   output logic [N_REQ-1:0]   done,
   output logic [7:0]         rx_data,
   output logic               err_timeout,
   output logic               spi_ss_n,
   output logic [7:0]         spi_spcr,
   output logic [7:0]         spi_spibr,
   output logic [7:0]         spi_txdata,
   output logic               spi_load,
   input  logic               spi_spif,
   input  logic [7:0]         spi_rxdata
);

   localparam int IW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int TW      = $clog2(TIMEOUT_CYC + 1);
   localparam int SEQ_MAX = (SETUP_CYC > SS_GAP) ? SETUP_CYC : SS_GAP;
   localparam int SW      = $clog2(SEQ_MAX + 1);
   localparam logic [7:0] SPCR_RST = 8'h10;
   localparam logic [7:0] SPE_CLR  = 8'hBF;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETUP   = 3'd1,
      ST_LOAD    = 3'd2,
      ST_WAIT    = 3'd3,
      ST_DONE    = 3'd4,
      ST_RELEASE = 3'd5
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;
   logic [IW-1:0]     ptr_r;
   logic [IW-1:0]     ptr_nxt_s;
   logic [SW-1:0]     seq_cnt_r;
   logic [SW-1:0]     seq_nxt_s;
   logic [TW-1:0]     tmo_cnt_r;
   logic [TW-1:0]     tmo_nxt_s;
   logic [N_REQ-1:0]  gnt_nxt_s;
   logic [N_REQ-1:0]  done_nxt_s;
   logic [7:0]        rx_nxt_s;
   logic              err_nxt_s;
   logic              ss_nxt_s;
   logic [7:0]        spcr_nxt_s;
   logic [7:0]        spibr_nxt_s;
   logic [7:0]        txd_nxt_s;
   logic              load_nxt_s;

   logic              pick_valid_s;
   logic [IW-1:0]     pick_idx_s;
   logic [IW-1:0]     cand_s;
   logic [7:0]        tx_byte_s [N_REQ];

   // Split the packed client data bus into per-requester bytes
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         tx_byte_s[i] = tx_data[8*i +: 8];
      end
   end

   // Round-robin pick: scan from farthest to nearest so the first set bit after ptr wins
   always_comb begin
      pick_valid_s = 1'b0;
      pick_idx_s   = '0;
      cand_s       = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         cand_s       = IW'((int'(ptr_r) + k) % N_REQ);
         pick_idx_s   = req[cand_s] ? cand_s : pick_idx_s;
         pick_valid_s = pick_valid_s | req[cand_s];
      end
   end

   // Next-state and next-output logic for the transaction sequencer
   always_comb begin
      state_nxt_s = state_r;
      ptr_nxt_s   = ptr_r;
      seq_nxt_s   = seq_cnt_r;
      tmo_nxt_s   = tmo_cnt_r;
      gnt_nxt_s   = gnt;
      done_nxt_s  = '0;
      rx_nxt_s    = rx_data;
      err_nxt_s   = 1'b0;
      ss_nxt_s    = spi_ss_n;
      spcr_nxt_s  = spi_spcr;
      spibr_nxt_s = spi_spibr;
      txd_nxt_s   = spi_txdata;
      load_nxt_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            seq_nxt_s = '0;
            if (pick_valid_s) begin
               state_nxt_s = ST_SETUP;
               ptr_nxt_s   = pick_idx_s;
               gnt_nxt_s   = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
               ss_nxt_s    = 1'b0;
               spcr_nxt_s  = {1'b0, 1'b1, 1'b0, 1'b1, cfg_cpol, cfg_cpha, 2'b00};
               spibr_nxt_s = cfg_prescale;
               txd_nxt_s   = tx_byte_s[pick_idx_s];
            end else begin
               ss_nxt_s = 1'b1;
            end
         end
         ST_SETUP: begin
            if (seq_cnt_r == SW'(SETUP_CYC - 1)) begin
               state_nxt_s = ST_LOAD;
               load_nxt_s  = 1'b1;
            end else begin
               seq_nxt_s = seq_cnt_r + SW'(1);
            end
         end
         ST_LOAD: begin
            state_nxt_s = ST_WAIT;
            tmo_nxt_s   = '0;
         end
         ST_WAIT: begin
            // SPIF takes priority over a timeout expiring in the same cycle
            if (spi_spif) begin
               state_nxt_s = ST_DONE;
               done_nxt_s  = gnt;
               rx_nxt_s    = spi_rxdata;
            end else if (tmo_cnt_r == TW'(TIMEOUT_CYC - 1)) begin
               state_nxt_s = ST_DONE;
               done_nxt_s  = gnt;
               rx_nxt_s    = 8'h00;
               err_nxt_s   = 1'b1;
            end else begin
               tmo_nxt_s = tmo_cnt_r + TW'(1);
            end
         end
         ST_DONE: begin
            // err_timeout is still high here exactly when this byte timed out
            if (lock[ptr_r] && !err_timeout && req[ptr_r]) begin
               state_nxt_s = ST_LOAD;
               load_nxt_s  = 1'b1;
               txd_nxt_s   = tx_byte_s[ptr_r];
            end else begin
               state_nxt_s = ST_RELEASE;
               ss_nxt_s    = 1'b1;
               spcr_nxt_s  = spi_spcr & SPE_CLR;
               gnt_nxt_s   = '0;
               seq_nxt_s   = '0;
            end
         end
         ST_RELEASE: begin
            if (seq_cnt_r == SW'(SS_GAP - 1)) begin
               state_nxt_s = ST_IDLE;
            end else begin
               seq_nxt_s = seq_cnt_r + SW'(1);
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            ss_nxt_s    = 1'b1;
            gnt_nxt_s   = '0;
         end
      endcase
   end

   // State, counters and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         ptr_r       <= IW'(N_REQ - 1);
         seq_cnt_r   <= '0;
         tmo_cnt_r   <= '0;
         gnt         <= '0;
         done        <= '0;
         rx_data     <= 8'h00;
         err_timeout <= 1'b0;
         spi_ss_n    <= 1'b1;
         spi_spcr    <= SPCR_RST;
         spi_spibr   <= 8'h00;
         spi_txdata  <= 8'h00;
         spi_load    <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         ptr_r       <= ptr_nxt_s;
         seq_cnt_r   <= seq_nxt_s;
         tmo_cnt_r   <= tmo_nxt_s;
         gnt         <= gnt_nxt_s;
         done        <= done_nxt_s;
         rx_data     <= rx_nxt_s;
         err_timeout <= err_nxt_s;
         spi_ss_n    <= ss_nxt_s;
         spi_spcr    <= spcr_nxt_s;
         spi_spibr   <= spibr_nxt_s;
         spi_txdata  <= txd_nxt_s;
         spi_load    <= load_nxt_s;
      end
   end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Self-checking bench for spi_xfer_arbiter: SPI slave responder, done scoreboard,
// a table of single-byte transactions and hand sequences for arbitration, bursts, timeout and reset.
module tb_spi_xfer_arbiter;
   localparam int N_REQ       = 4;
   localparam int SS_GAP      = 4;
   localparam int SETUP_CYC   = 2;
   localparam int TIMEOUT_CYC = 1024;

   logic               clk = 1'b0;
   logic               rst;
   logic [N_REQ-1:0]   req;
   logic [8*N_REQ-1:0] tx_data;
   logic [N_REQ-1:0]   lock;
   logic               cfg_cpol, cfg_cpha;
   logic [7:0]         cfg_prescale;
   logic [N_REQ-1:0]   gnt, done;
   logic [7:0]         rx_data;
   logic               err_timeout, spi_ss_n;
   logic [7:0]         spi_spcr, spi_spibr, spi_txdata;
   logic               spi_load;
   logic               spi_spif;
   logic [7:0]         spi_rxdata;

   always #5 clk = ~clk;

   spi_xfer_arbiter #(.N_REQ(N_REQ), .SS_GAP(SS_GAP), .SETUP_CYC(SETUP_CYC),
                      .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
      .clk(clk), .rst(rst), .req(req), .tx_data(tx_data), .lock(lock),
      .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha), .cfg_prescale(cfg_prescale),
      .gnt(gnt), .done(done), .rx_data(rx_data), .err_timeout(err_timeout),
      .spi_ss_n(spi_ss_n), .spi_spcr(spi_spcr), .spi_spibr(spi_spibr),
      .spi_txdata(spi_txdata), .spi_load(spi_load), .spi_spif(spi_spif),
      .spi_rxdata(spi_rxdata));

   typedef struct {
      int         idx;
      logic [7:0] tx;
      logic [7:0] rx;
      logic       tmo;
   } exp_t;

   typedef struct {
      int         idx;
      logic [7:0] tx;
      logic [7:0] rx;
      logic [7:0] presc;
      logic       cpol;
      logic       cpha;
      logic [7:0] exp_spcr;
   } vec_t;

   exp_t       sb[$];
   logic [7:0] slave_q[$];
   bit         slave_en;
   int         spif_delay;
   int         vectors = 0;
   int         miscompares = 0;
   int         load_cnt = 0;
   logic [7:0] last_load_tx = 8'h00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      repeat (SS_GAP + 3) tick();
   endtask

   // Serve pending requests, dropping each req on its done; reports smallest SS-high gap between transactions
   task automatic serve(input int maxc, output int min_gap);
      int gap;
      int seen;
      gap = 0;
      seen = 0;
      min_gap = 1000;
      for (int c = 0; c < maxc; c++) begin
         tick();
         for (int k = 0; k < N_REQ; k++) begin
            if (done[k] && !lock[k]) req[k] = 1'b0;
         end
         if (spi_ss_n) begin
            gap++;
         end else begin
            if (seen > 0 && gap > 0 && gap < min_gap) min_gap = gap;
            gap = 0;
         end
         if (done != '0) seen++;
         if (req == '0) break;
      end
      chk("all_served", 32'(req), 32'd0);
      req = '0;
   endtask

   // SPI slave responder plus done scoreboard
   initial begin : mon
      int   pend;
      exp_t e;
      pend = -1;
      spi_spif = 1'b0;
      spi_rxdata = 8'h00;
      forever begin
         tick();
         spi_spif = 1'b0;
         if (rst) begin
            pend = -1;
         end else begin
            if (spi_load) begin
               load_cnt++;
               last_load_tx = spi_txdata;
               if (slave_en) pend = spif_delay;
            end else if (pend > 0) begin
               pend--;
               if (pend == 0) begin
                  spi_spif = 1'b1;
                  spi_rxdata = (slave_q.size() > 0) ? slave_q.pop_front() : 8'hEE;
                  pend = -1;
               end
            end
            if (done != '0) begin
               if (sb.size() == 0) begin
                  chk("unexpected_done", 32'(done), 32'd0);
               end else begin
                  e = sb.pop_front();
                  chk("done_onehot", 32'(done), 32'(1 << e.idx));
                  chk("gnt_at_done", 32'(gnt), 32'(1 << e.idx));
                  chk("rx_data", 32'(rx_data), 32'(e.rx));
                  chk("err_timeout", 32'(err_timeout), 32'(e.tmo));
                  chk("tx_at_load", 32'(last_load_tx), 32'(e.tx));
               end
            end else if (err_timeout) begin
               chk("err_without_done", 32'(err_timeout), 32'd0);
            end
         end
      end
   end

   initial begin : watchdog
      #1ms;
      $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
      $fatal(1, "watchdog expired");
   end

   vec_t tbl[4];
   int   lat, l0, g, nd, nl, ss_high, ss_rise, gnt_bad, lc, dc, bad, saw;
   logic prev_ss, started;

   initial begin : main
      tbl[0] = '{0, 8'hAA, 8'h55, 8'h02, 1'b0, 1'b0, 8'h50};
      tbl[1] = '{1, 8'h3C, 8'hC3, 8'h10, 1'b0, 1'b1, 8'h54};
      tbl[2] = '{3, 8'h01, 8'hFE, 8'h7F, 1'b1, 1'b0, 8'h58};
      tbl[3] = '{2, 8'h80, 8'h00, 8'hFF, 1'b1, 1'b1, 8'h5C};

      rst = 1'b1; req = '0; tx_data = '0; lock = '0;
      cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_prescale = 8'h00;
      slave_en = 1'b1; spif_delay = 4;
      repeat (3) tick();
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_rx", 32'(rx_data), 32'd0);
      chk("rst_err", 32'(err_timeout), 32'd0);
      chk("rst_ss_n", 32'(spi_ss_n), 32'd1);
      chk("rst_spcr", 32'(spi_spcr), 32'h10);
      chk("rst_spibr", 32'(spi_spibr), 32'd0);
      chk("rst_txdata", 32'(spi_txdata), 32'd0);
      chk("rst_load", 32'(spi_load), 32'd0);
      rst = 1'b0;
      tick();

      // Table of isolated single-byte transactions
      for (int v = 0; v < 4; v++) begin
         cfg_cpol = tbl[v].cpol; cfg_cpha = tbl[v].cpha; cfg_prescale = tbl[v].presc;
         tx_data[8*tbl[v].idx +: 8] = tbl[v].tx;
         slave_q.push_back(tbl[v].rx);
         sb.push_back('{tbl[v].idx, tbl[v].tx, tbl[v].rx, 1'b0});
         l0 = load_cnt;
         lat = -1;
         req[tbl[v].idx] = 1'b1;
         for (int c = 1; c <= 40; c++) begin
            tick();
            if (c == 1) begin
               chk("grant", 32'(gnt), 32'(1 << tbl[v].idx));
               chk("ss_low", 32'(spi_ss_n), 32'd0);
            end
            if (spi_load && lat < 0) begin
               lat = c;
               chk("spcr", 32'(spi_spcr), 32'(tbl[v].exp_spcr));
               chk("spibr", 32'(spi_spibr), 32'(tbl[v].presc));
               chk("txdata", 32'(spi_txdata), 32'(tbl[v].tx));
            end
            if (done[tbl[v].idx]) break;
         end
         req = '0;
         chk("load_latency", 32'(lat), 32'(1 + SETUP_CYC));
         settle();
         chk("ss_high_after", 32'(spi_ss_n), 32'd1);
         chk("one_load", 32'(load_cnt - l0), 32'd1);
         chk("sb_empty_tbl", 32'(sb.size()), 32'd0);
      end

      // Simultaneous req0+req2 with last winner 2: req0 first, then req2, then req3 beats req0
      tx_data[7:0] = 8'hBB; tx_data[23:16] = 8'hBC;
      slave_q.push_back(8'h31); slave_q.push_back(8'h32);
      sb.push_back('{0, 8'hBB, 8'h31, 1'b0});
      sb.push_back('{2, 8'hBC, 8'h32, 1'b0});
      req = 4'b0101;
      serve(200, g);
      chk("ss_gap_ge", 32'(g >= SS_GAP), 32'd1);
      settle();
      chk("sb_empty_rr", 32'(sb.size()), 32'd0);
      tx_data[7:0] = 8'h0A; tx_data[31:24] = 8'h3A;
      slave_q.push_back(8'h41); slave_q.push_back(8'h42);
      sb.push_back('{3, 8'h3A, 8'h41, 1'b0});
      sb.push_back('{0, 8'h0A, 8'h42, 1'b0});
      req = 4'b1001;
      serve(200, g);
      settle();
      chk("sb_empty_tie", 32'(sb.size()), 32'd0);

      // Locked 3-byte burst on req1; req0 arrives mid-burst and must wait
      tx_data[15:8] = 8'hFB; lock[1] = 1'b1;
      slave_q.push_back(8'hA1); slave_q.push_back(8'hA2);
      slave_q.push_back(8'hA3); slave_q.push_back(8'hA4);
      sb.push_back('{1, 8'hFB, 8'hA1, 1'b0});
      sb.push_back('{1, 8'hAC, 8'hA2, 1'b0});
      sb.push_back('{1, 8'h11, 8'hA3, 1'b0});
      sb.push_back('{0, 8'h5A, 8'hA4, 1'b0});
      nd = 0; nl = 0; ss_high = 0; ss_rise = 0; gnt_bad = 0;
      started = 1'b0; prev_ss = spi_ss_n;
      req[1] = 1'b1;
      for (int c = 0; c < 300; c++) begin
         tick();
         if (!spi_ss_n) started = 1'b1;
         if (spi_load) begin
            nl++;
            if (nl == 3) lock[1] = 1'b0;
         end
         if (started && nd < 3 && spi_ss_n) ss_high++;
         if (started && nd < 3 && gnt != 4'b0010) gnt_bad++;
         if (!prev_ss && spi_ss_n) ss_rise++;
         prev_ss = spi_ss_n;
         if (done[1]) begin
            nd++;
            if (nd == 1) begin
               tx_data[15:8] = 8'hAC; tx_data[7:0] = 8'h5A; req[0] = 1'b1;
            end
            if (nd == 2) tx_data[15:8] = 8'h11;
            if (nd == 3) req[1] = 1'b0;
         end
         if (done[0]) break;
      end
      req = '0; lock = '0;
      chk("burst_dones", 32'(nd), 32'd3);
      chk("burst_ss_high", 32'(ss_high), 32'd0);
      chk("burst_gnt_held", 32'(gnt_bad), 32'd0);
      chk("burst_one_release", 32'(ss_rise), 32'd1);
      chk("burst_loads", 32'(nl), 32'd4);
      settle();
      chk("sb_empty_burst", 32'(sb.size()), 32'd0);

      // SPIF never arrives: timeout after TIMEOUT_CYC cycles in WAIT
      slave_en = 1'b0;
      tx_data[23:16] = 8'h77;
      sb.push_back('{2, 8'h77, 8'h00, 1'b1});
      lc = -1; dc = -1;
      req[2] = 1'b1;
      for (int c = 0; c < TIMEOUT_CYC + 50; c++) begin
         tick();
         if (spi_load) lc = c;
         if (done[2]) begin
            dc = c;
            break;
         end
      end
      req = '0;
      chk("timeout_cycles", 32'(dc - lc), 32'(TIMEOUT_CYC + 1));
      settle();
      chk("timeout_ss_high", 32'(spi_ss_n), 32'd1);
      chk("sb_empty_tmo", 32'(sb.size()), 32'd0);

      // Reset while waiting on SPIF, then req0/req3 pending across reset release
      req[1] = 1'b1;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (spi_load) break;
      end
      repeat (3) tick();
      rst = 1'b1; req = '0;
      tick();
      chk("mid_rst_gnt", 32'(gnt), 32'd0);
      chk("mid_rst_ss_n", 32'(spi_ss_n), 32'd1);
      chk("mid_rst_spcr", 32'(spi_spcr), 32'h10);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_load", 32'(spi_load), 32'd0);
      chk("mid_rst_txdata", 32'(spi_txdata), 32'd0);
      tx_data[7:0] = 8'h0F; tx_data[31:24] = 8'hF0;
      slave_en = 1'b1;
      slave_q.push_back(8'h61); slave_q.push_back(8'h62);
      sb.push_back('{0, 8'h0F, 8'h61, 1'b0});
      sb.push_back('{3, 8'hF0, 8'h62, 1'b0});
      req = 4'b1001;
      tick();
      rst = 1'b0;
      serve(200, g);
      settle();
      chk("sb_empty_rst", 32'(sb.size()), 32'd0);

      // Config and tx_data changes after grant, plus req drop, must not disturb the transaction
      cfg_cpol = 1'b1; cfg_cpha = 1'b1; cfg_prescale = 8'h21;
      tx_data[31:24] = 8'h42;
      spif_delay = 10;
      slave_q.push_back(8'h66);
      sb.push_back('{3, 8'h42, 8'h66, 1'b0});
      bad = 0; saw = 0;
      req[3] = 1'b1;
      for (int c = 1; c <= 60; c++) begin
         tick();
         if (c == 1) begin
            cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_prescale = 8'h99;
            tx_data[31:24] = 8'hC3; req[3] = 1'b0;
         end
         if (gnt != '0) begin
            if (spi_spcr != 8'h5C) bad++;
            if (spi_spibr != 8'h21) bad++;
         end
         if (done[3]) begin
            saw = 1;
            break;
         end
      end
      chk("cfg_stable", 32'(bad), 32'd0);
      chk("done_after_req_drop", 32'(saw), 32'd1);
      settle();
      chk("sb_empty_cfg", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
